// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding and pattern constant for the 1101 sequence detector
package seq_det_pkg;

    localparam logic [3:0] PATTERN = 4'b1101;
    localparam int         STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_1    = 3'd1;
    localparam state_t S_11   = 3'd2;
    localparam state_t S_110  = 3'd3;
    localparam state_t S_DET  = 3'd4;

    // A freshly detected "1101" leaves a trailing "1", so S_DET behaves like S_1.
    // Encodings 5..7 are unreachable and fall back to S_IDLE.
    function automatic state_t next_state(input state_t s, input logic b);
        return (s == S_IDLE) ? (b ? S_1   : S_IDLE) :
               (s == S_1)    ? (b ? S_11  : S_IDLE) :
               (s == S_11)   ? (b ? S_11  : S_110)  :
               (s == S_110)  ? (b ? S_DET : S_IDLE) :
               (s == S_DET)  ? (b ? S_11  : S_IDLE) :
                               S_IDLE;
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// seq_det_core: Moore FSM recognising overlapping 1101 on a serial input
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sin,
    output logic detected
);

    state_t state;
    state_t state_nxt;

    // Next state from the current state and the sampled bit.
    always_comb begin
        state_nxt = next_state(state, sin);
    end

    // State register; rst low clears it immediately, aborting any partial match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Output decoded from state only, so it never follows sin combinationally.
    always_comb begin
        detected = (state == S_DET);
    end

endmodule

// File: rtl/seq_det_verilog_pp.sv
// seq_det_verilog_pp: 1101 serial sequence detector with active-low async reset
module seq_det_verilog_pp (
    input  logic clk,
    input  logic rst,
    input  logic SIn,
    output logic detected
);

    seq_det_core u_core (
        .clk      (clk),
        .rst      (rst),
        .sin      (SIn),
        .detected (detected)
    );

endmodule

// File: tb/tb_seq_det_verilog_pp.sv
// tb_seq_det_verilog_pp: randomized and directed checks against a bit-history model
module tb_seq_det_verilog_pp;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic SIn = 1'b0;
    logic detected;

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;

    // Model: the last four bits sampled since reset and how many are valid.
    logic [3:0] hist = 4'b0;
    int nvalid = 0;

    seq_det_verilog_pp dut (
        .clk      (clk),
        .rst      (rst),
        .SIn      (SIn),
        .detected (detected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one bit, glitching it mid-period so only the value at the edge counts.
    task automatic step(input string tag, input logic b);
        logic exp;
        @(negedge clk);
        SIn = ~b;
        #2;
        SIn = b;
        @(posedge clk);
        if (rst) begin
            hist = {hist[2:0], b};
            if (nvalid < 4) nvalid++;
        end
        #1;
        exp = rst && nvalid >= 4 && hist == 4'b1101;
        check(tag, detected, exp);
        if (detected) pulses++;
    endtask

    // Assert reset mid-cycle, clock random bits through it, release away from the edge.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", detected, 1'b0);
        nvalid = 0;
        hist = 4'b0;
        for (int i = 0; i < cycles; i++) step("rst_hold", 1'($urandom_range(0, 1)));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_release", detected, 1'b0);
    endtask

    task automatic run_seq(input string tag, input logic [15:0] bits, input int len, input int exp_pulses);
        pulses = 0;
        for (int i = len - 1; i >= 0; i--) step(tag, bits[i]);
        check({tag, "_pulses"}, 1'(pulses == exp_pulses), 1'b1);
    endtask

    initial begin
        do_reset(5);
        run_seq("basic", 16'b11010, 5, 1);
        do_reset(1);
        run_seq("overlap", 16'b1101101, 7, 2);
        do_reset(1);
        run_seq("near_miss", 16'b1010011100, 10, 0);
        do_reset(1);
        run_seq("long_run", 16'b111111111101, 12, 1);
        do_reset(1);
        step("pre_mid", 1'b1);
        step("pre_mid", 1'b1);
        step("pre_mid", 1'b0);
        step("pre_mid", 1'b1);
        check("mid_det_high", detected, 1'b1);
        do_reset(2);
        run_seq("post_mid", 16'b1101, 4, 1);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 3) do_reset(int'($urandom_range(1, 3)));
            else step("rand", ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_det_verilog_pp.md
SEQ_DET_VERILOG_PP -- requirements
Module: seq_det_verilog_pp

Interface
REQ-001 The block SHALL have no parameters; the detected pattern is fixed at 4'b1101, MSB received first.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 rst  input  1  reset, asynchronous and active-low (rst=0 resets, rst=1 runs).
REQ-004 SIn  input  1  serial data bit, one bit sampled per rising clk edge.
REQ-005 detected  output  1  high for one cycle when the last four sampled bits equal 1,1,0,1.
REQ-006 Ports SHALL appear in the order clk, rst, SIn, detected, so positional instantiation works.

Function
REQ-007 The block SHALL be a Moore FSM; detected SHALL depend on current state only, never combinationally on SIn.
REQ-008 States SHALL be S_IDLE (no useful prefix), S_1 ("1"), S_11 ("11"), S_110 ("110") and S_DET ("1101" just completed).
REQ-009 From S_IDLE: SIn=1 -> S_1; SIn=0 -> S_IDLE.
REQ-010 From S_1: SIn=1 -> S_11; SIn=0 -> S_IDLE.
REQ-011 From S_11: SIn=1 -> S_11; SIn=0 -> S_110.
REQ-012 From S_110: SIn=1 -> S_DET; SIn=0 -> S_IDLE.
REQ-013 From S_DET: SIn=1 -> S_11 (overlap: trailing "1" plus new "1"); SIn=0 -> S_IDLE.
REQ-014 Detection SHALL be overlapping: "1101101" SHALL produce two detections.
REQ-015 detected SHALL equal 1 exactly while the state is S_DET, else 0.
REQ-016 Latency: detected SHALL rise in the cycle after the rising edge that samples the final "1" and SHALL remain high for exactly one clock period.
REQ-017 detected SHALL never be high in two consecutive cycles, because S_DET has no self-loop.
REQ-018 Any unused state encoding SHALL transition to S_IDLE on the next edge, with detected=0.
REQ-019 SIn SHALL be treated as synchronous to clk; a value changing mid-period SHALL be taken as its value at the next rising edge.

Reset
REQ-020 rst=0 SHALL force the state to S_IDLE and detected to 0 immediately, without waiting for a clock edge.
REQ-021 While rst=0, SIn SHALL be ignored and detected SHALL stay 0.
REQ-022 After rst returns to 1, the first rising edge SHALL evaluate SIn from S_IDLE; no bits sampled before or during reset SHALL count toward a match.
REQ-023 Reset asserted mid-pattern, including while in S_DET, SHALL abort the pattern and clear detected in the same instant.

Structure
REQ-024 The state enumeration (5 states, 3-bit encoding) SHALL be defined in a shared package seq_det_pkg, together with the constant PATTERN = 4'b1101.
REQ-025 The block SHALL be one module: a state register with async reset, next-state logic and output decode.
REQ-026 No sub-module is required; an optional seq_det_core holding the FSM is acceptable.

Verification
REQ-027 Reset: rst=0 with SIn toggling for 5 cycles -> detected=0 throughout and state S_IDLE; release rst -> no spurious pulse.
REQ-028 Basic match: after reset, SIn=1,1,0,1 on 4 consecutive edges -> detected=1 for exactly the cycle after the 4th edge, then 0 if the next SIn is 0.
REQ-029 Overlap: SIn=1,1,0,1,1,0,1 -> detected pulses after the 4th and 7th edges, 2 pulses total.
REQ-030 Near misses: SIn=1,0,1,0,0,1,1,1,0,0 -> detected=0 on every cycle.
REQ-031 Long run: SIn=1 for 10 cycles, then 0, then 1 -> one detected pulse, after the final 1.
REQ-032 Async reset mid-detect: drive rst=0 mid-cycle while detected=1 -> detected=0 before the next clk edge; after release, SIn=1,1,0,1 -> one pulse.
